// File: rtl/coord_stack_pkg.sv
// Shared types for the parametrised coordinate stack.
// Coordinate pair layout and the per-cycle operation decode.
package coord_stack_pkg;

  localparam int COORD_W_DEFAULT = 4;

  typedef struct packed {
    logic [COORD_W_DEFAULT-1:0] x;
    logic [COORD_W_DEFAULT-1:0] y;
  } coord_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_CLEAR
  } op_e;

endpackage

// File: rtl/coord_stack_mem.sv
// Entry storage for the coordinate stack.
// One write port, one combinational read port; contents are not reset.
module coord_stack_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int IW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;

  assign widx = waddr[IW-1:0];
  assign ridx = raddr[IW-1:0];

  // Addresses at or beyond DEPTH never touch the array.
  always_ff @(posedge clk) begin
    if (we && (waddr < AW'(DEPTH))) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = (raddr < AW'(DEPTH)) ? mem[ridx] : '0;

endmodule

// File: rtl/coord_stack_param.sv
// Parametrised LIFO of (x,y) pairs with occupancy and error flags.
// The top entry is always visible on xOut/yOut.
module coord_stack_param
  import coord_stack_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [COORD_W-1:0] xIn,
  input  logic [COORD_W-1:0] yIn,
  output logic [COORD_W-1:0] xOut,
  output logic [COORD_W-1:0] yOut,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               full,
  output logic               fail,
  output logic               ovf_err,
  output logic               udf_err
);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pair_t;

  logic [CNT_W-1:0] count_q, count_d;
  logic             fail_q, fail_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  op_e              op;
  logic             we;
  logic [CNT_W-1:0] waddr;
  logic [CNT_W-1:0] top_idx;
  pair_t            wdata;
  pair_t            rdata;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign top_idx  = count_q - CNT_W'(1);
  assign wdata    = '{x: xIn, y: yIn};

  always_comb begin
    op = OP_NONE;
    priority case (1'b1)
      clear:        op = OP_CLEAR;
      push && pop:  op = is_empty ? OP_PUSH : OP_REPLACE;
      push:         op = OP_PUSH;
      pop:          op = OP_POP;
      default:      op = OP_NONE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    fail_d  = 1'b0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    we      = 1'b0;
    waddr   = count_q;
    unique case (op)
      OP_CLEAR: begin
        count_d = '0;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
      end
      OP_PUSH: begin
        if (is_full) begin
          fail_d = 1'b1;
          ovf_d  = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (is_empty) begin
          fail_d = 1'b1;
          udf_d  = 1'b1;
        end else begin
          count_d = top_idx;
        end
      end
      OP_REPLACE: begin
        we    = 1'b1;
        waddr = top_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      fail_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      fail_q  <= fail_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  coord_stack_mem #(
    .DEPTH (DEPTH),
    .W     (2*COORD_W),
    .AW    (CNT_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (top_idx),
    .rdata (rdata)
  );

  // Top is read straight from storage, so replace-top is coherent for free.
  assign xOut    = is_empty ? '0 : rdata.x;
  assign yOut    = is_empty ? '0 : rdata.y;
  assign count   = count_q;
  assign empty   = is_empty;
  assign full    = is_full;
  assign fail    = fail_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

endmodule

// File: tb/tb_coord_stack_param.sv
// Scoreboard bench for coord_stack_param (DEPTH=4, COORD_W=4).
// Expected state comes from a queue-based LIFO model.
module tb_coord_stack_param;
  import coord_stack_pkg::*;

  localparam int CW    = 4;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH+1);

  typedef struct packed {
    logic [CNTW-1:0] cnt;
    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic            emp;
    logic            ful;
    logic            fl;
    logic            ovf;
    logic            udf;
  } obs_t;

  logic            clk;
  logic            rst;
  logic            push, pop, clear;
  logic [CW-1:0]   xIn, yIn;
  logic [CW-1:0]   xOut, yOut;
  logic [CNTW-1:0] count;
  logic            empty, full, fail, ovf_err, udf_err;

  coord_stack_param #(
    .COORD_W (CW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .xIn     (xIn),
    .yIn     (yIn),
    .xOut    (xOut),
    .yOut    (yOut),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .fail    (fail),
    .ovf_err (ovf_err),
    .udf_err (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  coord_t mdl[$];
  logic   m_fail, m_ovf, m_udf;
  obs_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  event   mon_ev;

  function automatic obs_t expect_now();
    obs_t e;
    e.cnt = CNTW'(mdl.size());
    e.x   = (mdl.size() > 0) ? mdl[$].x : '0;
    e.y   = (mdl.size() > 0) ? mdl[$].y : '0;
    e.emp = (mdl.size() == 0);
    e.ful = (mdl.size() == DEPTH);
    e.fl  = m_fail;
    e.ovf = m_ovf;
    e.udf = m_udf;
    return e;
  endfunction

  task automatic model_reset();
    mdl.delete();
    m_fail = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic o,
                            input logic c, input coord_t v);
    m_fail = 1'b0;
    if (c) begin
      mdl.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (p && o) begin
      if (mdl.size() == 0) mdl.push_back(v);
      else mdl[mdl.size()-1] = v;
    end else if (p) begin
      if (mdl.size() == DEPTH) begin
        m_fail = 1'b1;
        m_ovf  = 1'b1;
      end else begin
        mdl.push_back(v);
      end
    end else if (o) begin
      if (mdl.size() == 0) begin
        m_fail = 1'b1;
        m_udf  = 1'b1;
      end else begin
        void'(mdl.pop_back());
      end
    end
  endtask

  task automatic step(input logic p, input logic o, input logic c,
                      input logic [CW-1:0] x, input logic [CW-1:0] y);
    coord_t v;
    @(negedge clk);
    #1;
    push  = p;
    pop   = o;
    clear = c;
    xIn   = x;
    yIn   = y;
    v.x = x;
    v.y = y;
    @(posedge clk);
    #1;
    model_step(p, o, c, v);
    sb.push_back(expect_now());
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  always begin
    @(negedge clk or mon_ev);
    if (sb.size() > 0) begin
      obs_t e, a;
      e = sb.pop_front();
      a.cnt = count;
      a.x   = xOut;
      a.y   = yOut;
      a.emp = empty;
      a.ful = full;
      a.fl  = fail;
      a.ovf = ovf_err;
      a.udf = udf_err;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL chk%0d state: got cnt=%0d xy=(%0h,%0h) e=%b f=%b fail=%b ovf=%b udf=%b; exp cnt=%0d xy=(%0h,%0h) e=%b f=%b fail=%b ovf=%b udf=%b",
                 checks, a.cnt, a.x, a.y, a.emp, a.ful, a.fl, a.ovf, a.udf,
                 e.cnt, e.x, e.y, e.emp, e.ful, e.fl, e.ovf, e.udf);
      end
    end
  end

  initial begin
    int r;
    int wait_cyc;
    rst   = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
    xIn   = '0;
    yIn   = '0;
    model_reset();
    #1;
    sb.push_back(expect_now());
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    idle();
    idle();

    step(1, 0, 0, 4'h1, 4'h0);
    step(1, 0, 0, 4'h2, 4'h3);
    step(1, 0, 0, 4'h4, 4'h5);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 4'(i + 8), 4'(i + 1));
    step(1, 0, 0, 4'h9, 4'h9);
    step(1, 0, 0, 4'h9, 4'h9);
    idle();

    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    idle();
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 4'h7, 4'h7);

    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 4'h3, 4'h3);
    step(1, 1, 0, 4'h6, 4'h1);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 4'h2, 4'hA);
    for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 0, 4'(i), 4'(i + 3));
    step(1, 1, 0, 4'hF, 4'hF);
    step(1, 1, 1, 4'h5, 4'h5);

    step(1, 0, 0, 4'hC, 4'hD);
    step(1, 0, 0, 4'hE, 4'h1);
    idle();
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sb.push_back(expect_now());
    #1;
    ->mon_ev;
    @(negedge clk);
    #1;
    rst = 1'b1;
    step(0, 1, 0, 0, 0);
    idle();

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       step(0, 0, 1, 0, 0);
      else if (r < 18) step(1, 1, 0, 4'($urandom), 4'($urandom));
      else if (r < 58) step(1, 0, 0, 4'($urandom), 4'($urandom));
      else if (r < 90) step(0, 1, 0, 0, 0);
      else             step(0, 0, 0, 4'($urandom), 4'($urandom));
    end
    idle();

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never checked", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coord_stack_param.md
Name: coord_stack_param

Overview:
Parametrised LIFO of (x,y) coordinate pairs for the maze/path-search datapath. It is the successor to the fixed 4-bit coordinate stack. It adds configurable coordinate width and depth, occupancy flags and count, simultaneous push+pop (replace-top), synchronous clear, and distinct sticky overflow/underflow error flags alongside the pulsed fail. The top of stack is always presented on xOut/yOut, so the search FSM can backtrack without a separate read cycle.

Parameters:
COORD_W, 4, width of each coordinate (x and y separately)
DEPTH, 16, number of entries; any integer >= 2, need not be a power of two
CNT_W, $clog2(DEPTH+1), width of count; derived, not to be overridden

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low
push  in  1  push {xIn,yIn} this cycle
pop  in  1  remove top entry this cycle
clear  in  1  synchronous flush; empties stack and clears sticky errors
xIn  in  COORD_W  x coordinate to push
yIn  in  COORD_W  y coordinate to push
xOut  out  COORD_W  x of current top entry; 0 when empty
yOut  out  COORD_W  y of current top entry; 0 when empty
count  out  CNT_W  number of valid entries, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
fail  out  1  one-cycle pulse on a rejected operation
ovf_err  out  1  sticky: a push was rejected while full
udf_err  out  1  sticky: a pop was rejected while empty

Behaviour:
- Reset (rst=0, asynchronous): count=0, empty=1, full=0, xOut=yOut=0, fail=0, ovf_err=udf_err=0. Storage contents are don't-care and are not reset.
- All state updates occur on the rising clk edge. Outputs are registered or derived from registers, so the effect of an edge is visible immediately after that edge, with no extra read latency.
- Operation decode per cycle, priority top-down:
  - clear=1: count<=0; ovf_err, udf_err<=0; fail<=0; push and pop are ignored.
  - push=1, pop=0, not full: write {xIn,yIn} at index count; count+1; the new entry becomes the top.
  - push=1, pop=0, full: no state change; fail pulses 1 for one cycle; ovf_err<=1.
  - pop=1, push=0, not empty: count-1; the top becomes the entry below, or 0/0 if the stack is now empty.
  - pop=1, push=0, empty: no change; fail pulses; udf_err<=1.
  - push=1, pop=1, not empty: replace top with {xIn,yIn}; count unchanged. Legal when full; no fail.
  - push=1, pop=1, empty: treated as a plain push; count becomes 1; no fail.
  - neither: hold; fail<=0.
- fail is high for exactly the cycle following the rejected request edge and is not held by level inputs. A sustained illegal push pulses fail on every cycle it is sampled.
- Sticky errors stay set until clear or reset. Rejected operations never corrupt contents or count.
- xOut/yOut equal storage[count-1] when count>0, else 0. A top-of-stack register is permitted, but it must stay coherent under replace-top.
- Width rules: count never exceeds DEPTH. Index arithmetic uses CNT_W bits with no wrap; wrap-around is impossible by construction.
- Reset asserted mid-operation aborts any in-flight push or pop. Deassertion is expected to be synchronised externally.

Decomposition:
- Shared package coord_stack_pkg holds:
  - COORD_W_DEFAULT=4
  - coord_t, a packed struct {x,y} sized by COORD_W
  - the op-decode enum {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_CLEAR}
- One sub-module, coord_stack_mem: DEPTH x 2*COORD_W register array with a single write port and an asynchronous read port.
- Control, count and flags stay in coord_stack_param.

Test Plan:
- Reset then idle -> count=0, empty=1, xOut=yOut=0, fail=0, no errors.
- DEPTH=4: push (1,0),(2,3),(4,5) -> count=3, top=(4,5). Pop -> top=(2,3), count=2. Pop, pop -> empty=1, xOut=yOut=0.
- DEPTH=4: fill with 4 pushes (full=1), push (9,9) -> fail pulses one cycle, ovf_err=1, top unchanged (4th value), count=4.
- Pop on empty -> fail pulse, udf_err=1. Then clear -> udf_err=0. Subsequent push (7,7) -> count=1, top=(7,7).
- Push (3,3) then push+pop (6,1) -> count=1, top=(6,1). At full, push+pop (0xF,0xF) -> count=DEPTH, top=(F,F), no fail.
- Push 2 entries, drive rst=0 asynchronously mid-cycle -> outputs drop to reset values before the next clk edge. After release, pop -> udf_err=1.
